// File: rtl/sys_skew_feeder.sv
// -----------------------------------------------------------------------------
// sys_skew_feeder
//
// Input stage in front of the systolic PE array. Accepts row-parallel
// activation vectors over a valid/ready handshake, buffers them in a small
// FIFO, and applies the diagonal systolic skew: lane i reaches the array i
// cycles after lane 0. After the last vector of a tile, zero vectors are
// flushed through the skew so that every partial sum in the array completes.
//
// Parameters
//   ROWS   number of activation lanes (array rows)
//   DW     bits per activation
//   DEPTH  input FIFO depth in vectors (power of two, >= 2)
//
// Ports
//   clk           clock, all state on the rising edge
//   rst           asynchronous active-high reset
//   in_valid      upstream vector valid
//   in_ready      feeder can accept a vector (depends on the stored count only)
//   in_vec        activation vector, lane 0 in the MSBs
//   in_last       marks the final vector of a tile, sampled with in_vec
//   out_a_bus     skewed activations to the array, same lane ordering
//   out_fire      array fire strobe, high for every pop/bubble/flush beat
//   busy          feeder is streaming or flushing a tile
//   done          one-cycle pulse after the final flush beat
//   underrun_cnt  bubbles inserted in the current tile, saturating
// -----------------------------------------------------------------------------
module sys_skew_feeder #(
    parameter int ROWS  = 16,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ROWS*DW-1:0]   in_vec,
    input  logic                 in_last,
    output logic [ROWS*DW-1:0]   out_a_bus,
    output logic                 out_fire,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          underrun_cnt
);

    localparam int W   = ROWS * DW;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = AW + 1;
    localparam int FCW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [FCW-1:0]     flush_cnt_q, flush_cnt_d;
    logic               fire_q, fire_d;
    logic               done_q, done_d;
    logic [15:0]        underrun_q, underrun_d;

    // FIFO storage: {last, vector} per entry. The head is read
    // asynchronously because a pop must land in skew stage 0 on the same
    // edge; at this depth the array maps to distributed RAM.
    logic [W:0]         mem [0:DEPTH-1];
    logic [W:0]         head;

    logic               push;
    logic               pop;
    logic [W-1:0]       entry_vec;   // vector entering skew stage 0 this edge

    assign head     = mem[rd_ptr_q];
    assign in_ready = (count_q < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == STREAM) && (count_q != '0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        fire_d      = 1'b0;
        done_d      = 1'b0;
        underrun_d  = underrun_q;
        entry_vec   = '0;

        case (state_q)
            IDLE: begin
                // Entry edge only arms the stream; the first pop is on the
                // following edge. The bubble count belongs to the new tile.
                if (count_q != '0) begin
                    state_d    = STREAM;
                    underrun_d = '0;
                end
            end

            STREAM: begin
                fire_d = 1'b1;
                if (pop) begin
                    entry_vec = head[W-1:0];
                    if (head[W]) begin
                        if (ROWS == 1) begin
                            // Nothing to drain behind a single lane.
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d     = FLUSH;
                            flush_cnt_d = FCW'(ROWS - 1);
                        end
                    end
                end else if (underrun_q != 16'hFFFF) begin
                    // FIFO ran dry mid-tile: a zero vector goes in instead.
                    underrun_d = underrun_q + 16'd1;
                end
            end

            FLUSH: begin
                // Zeros enter the skew; this beat is the last one when the
                // counter is about to reach zero.
                fire_d      = 1'b1;
                flush_cnt_d = flush_cnt_q - FCW'(1);
                if (flush_cnt_q == FCW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO bookkeeping. Pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            flush_cnt_q <= '0;
            fire_q      <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            flush_cnt_q <= flush_cnt_d;
            fire_q      <= fire_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
        end
    end

    // FIFO data array, no reset needed: entries are only read once written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {in_last, in_vec};
        end
    end

    // ------------------------------------------------------------------
    // Diagonal skew. Lane gi owns a chain of gi+1 registers: stage 0 is the
    // shared pop stage, the remaining gi stages provide the diagonal delay.
    // Outside STREAM/FLUSH entry_vec is zero, so the chains drain to zero.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_lane
            logic [DW-1:0] lane_q [0:gi];
            logic [DW-1:0] lane_d [0:gi];

            always_comb begin
                lane_d[0] = entry_vec[W-1-DW*gi -: DW];
                for (int j = 1; j <= gi; j++) begin
                    lane_d[j] = lane_q[j-1];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j <= gi; j++) begin
                        lane_q[j] <= '0;
                    end
                end else begin
                    for (int j = 0; j <= gi; j++) begin
                        lane_q[j] <= lane_d[j];
                    end
                end
            end

            assign out_a_bus[W-1-DW*gi -: DW] = lane_q[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_fire     = fire_q;
    assign done         = done_q;
    assign busy         = (state_q != IDLE);
    assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_sys_skew_feeder.sv
// -----------------------------------------------------------------------------
// Testbench for sys_skew_feeder. A behavioural model (a vector queue for the
// FIFO, a history of vectors entering the skew) runs on each clock edge and
// pushes the expected out_a_bus of every fire beat into a scoreboard queue.
// A monitor on the falling edge pops and compares whenever the DUT fires,
// and also checks the control outputs each cycle.
// -----------------------------------------------------------------------------
module tb_sys_skew_feeder;

    localparam int ROWS  = 16;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int W     = ROWS * DW;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_vec;
    logic            in_last;
    logic [W-1:0]    out_a_bus;
    logic            out_fire;
    logic            busy;
    logic            done;
    logic [15:0]     underrun_cnt;

    sys_skew_feeder #(.ROWS(ROWS), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_vec       (in_vec),
        .in_last      (in_last),
        .out_a_bus    (out_a_bus),
        .out_fire     (out_fire),
        .busy         (busy),
        .done         (done),
        .underrun_cnt (underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    // ------------------------------------------------------------------
    // Reference model: phase 0 = idle, 1 = streaming, 2 = flushing.
    // ------------------------------------------------------------------
    logic [W:0]    m_q[$];
    logic [W-1:0]  hist[$];          // vectors entering the skew, newest last
    logic [W-1:0]  sb[$];            // expected bus for each fire beat
    int            m_st  = 0;
    int            m_fc  = 0;
    int            m_und = 0;
    bit            m_acc = 0;
    logic          exp_fire = 0, exp_done = 0, exp_busy = 0, exp_ready = 1;
    logic [15:0]   exp_und = 0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_q.delete();
                sb.delete();
                hist.delete();
                repeat (ROWS) hist.push_back('0);
                m_st = 0; m_fc = 0; m_und = 0; m_acc = 0;
                exp_fire = 0; exp_done = 0; exp_busy = 0; exp_ready = 1; exp_und = 0;
            end else begin : step
                bit           push, fire, dn;
                logic [W:0]   e;
                logic [W-1:0] ent, expb, h;
                push = in_valid && (m_q.size() < DEPTH);
                fire = 0; dn = 0; ent = '0;
                case (m_st)
                    0: if (m_q.size() > 0) begin m_st = 1; m_und = 0; end
                    1: begin
                        fire = 1;
                        if (m_q.size() > 0) begin
                            e = m_q.pop_front();
                            ent = e[W-1:0];
                            if (e[W]) begin m_st = 2; m_fc = ROWS - 1; end
                        end else if (m_und < 65535) begin
                            m_und++;
                        end
                    end
                    default: begin
                        fire = 1;
                        m_fc--;
                        if (m_fc == 0) begin m_st = 0; dn = 1; end
                    end
                endcase
                if (push) m_q.push_back({in_last, in_vec});
                m_acc = push;
                hist.push_back(ent);
                void'(hist.pop_front());
                // Lane i shows the vector that entered i edges ago.
                expb = '0;
                for (int i = 0; i < ROWS; i++) begin
                    h = hist[ROWS-1-i];
                    expb[W-1-DW*i -: DW] = h[W-1-DW*i -: DW];
                end
                if (fire) sb.push_back(expb);
                exp_fire  = fire;
                exp_done  = dn;
                exp_busy  = (m_st != 0);
                exp_ready = (m_q.size() < DEPTH);
                exp_und   = 16'(m_und);
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    int cyc = 0;
    int cnt_fire = 0;
    int cnt_done = 0;
    int lane_hits [ROWS];
    int lane_cyc  [ROWS];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin : mon
                logic [W-1:0] e;
                chk("fire",     W'(out_fire),     W'(exp_fire));
                chk("done",     W'(done),         W'(exp_done));
                chk("busy",     W'(busy),         W'(exp_busy));
                chk("in_ready", W'(in_ready),     W'(exp_ready));
                chk("underrun", W'(underrun_cnt), W'(exp_und));
                if (out_fire) cnt_fire++;
                if (done)     cnt_done++;
                for (int i = 0; i < ROWS; i++) begin
                    if (out_a_bus[W-1-DW*i -: DW] != '0) begin
                        lane_hits[i]++;
                        lane_cyc[i] = cyc;
                    end
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("beat_bus", out_a_bus, e);
                end else begin
                    chk("idle_bus", out_a_bus, '0);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] v, input logic l);
        int n;
        in_vec = v; in_last = l; in_valid = 1'b1; n = 0;
        do begin tick(); n++; end while (!m_acc && n < 200);
        if (!m_acc) timeout_fail("send");
        in_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(m_st == 0 && m_q.size() == 0) && n < 500) begin tick(); n++; end
        if (n >= 500) timeout_fail("wait_idle");
        repeat (3) tick();
    endtask

    task automatic wait_flush();
        int n = 0;
        while (m_st != 2 && n < 100) begin tick(); n++; end
        if (n >= 100) timeout_fail("wait_flush");
    endtask

    task automatic clear_counts();
        cnt_fire = 0; cnt_done = 0;
        for (int i = 0; i < ROWS; i++) begin lane_hits[i] = 0; lane_cyc[i] = 0; end
    endtask

    function automatic logic [W-1:0] ramp(input int base);
        logic [W-1:0] v;
        for (int i = 0; i < ROWS; i++) v[W-1-DW*i -: DW] = DW'(base + i);
        return v;
    endfunction

    function automatic logic [W-1:0] fill(input logic [DW-1:0] b);
        logic [W-1:0] v;
        for (int i = 0; i < ROWS; i++) v[W-1-DW*i -: DW] = b;
        return v;
    endfunction

    // Single all-0x01 vector tile: each lane lights up once, i cycles late.
    task automatic single_tile();
        clear_counts();
        send(fill(8'h01), 1'b1);
        wait_idle();
        chk("s1_fire_cycles", W'(cnt_fire), W'(ROWS));
        chk("s1_done_pulses", W'(cnt_done), W'(1));
        chk("s1_underrun",    W'(underrun_cnt), W'(0));
        for (int i = 0; i < ROWS; i++) begin
            chk($sformatf("s1_lane%0d_hits", i), W'(lane_hits[i]), W'(1));
            chk($sformatf("s1_lane%0d_delay", i), W'(lane_cyc[i] - lane_cyc[0]), W'(i));
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b0; in_valid = 1'b0; in_vec = '0; in_last = 1'b0;
        clear_counts();
        #1 rst = 1'b1;
        #1;
        chk("rst_bus",      out_a_bus,        '0);
        chk("rst_fire",     W'(out_fire),     W'(0));
        chk("rst_busy",     W'(busy),         W'(0));
        chk("rst_done",     W'(done),         W'(0));
        chk("rst_underrun", W'(underrun_cnt), W'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", W'(in_ready), W'(1));
        tick();

        // Scenario 1: single vector tile.
        single_tile();

        // Scenario 2: 31 back-to-back ramp vectors.
        clear_counts();
        for (int n = 0; n < 31; n++) send(ramp(n), n == 30);
        wait_idle();
        chk("s2_underrun",    W'(underrun_cnt), W'(0));
        chk("s2_fire_cycles", W'(cnt_fire),     W'(31 + ROWS - 1));
        chk("s2_done_pulses", W'(cnt_done),     W'(1));

        // Scenario 3: upstream stalls after the first vector of a tile.
        send(ramp(40), 1'b0);
        gap(4);
        for (int n = 1; n < 6; n++) send(ramp(40 + n), n == 5);
        wait_idle();
        chk("s3_underrun", W'(underrun_cnt), W'(3));

        // Scenarios 4/6: second tile pushed during the first tile's flush.
        send(ramp(60), 1'b0);
        send(ramp(61), 1'b1);
        wait_flush();
        for (int n = 0; n < 4; n++) send(ramp(70 + n), 1'b0);
        chk("s4_full_ready", W'(in_ready), W'(0));
        send(ramp(74), 1'b1);
        wait_idle();

        // Scenario 5: reset during flush, then a clean tile.
        clear_counts();
        send(fill(8'h01), 1'b1);
        wait_flush();
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("s5_bus_now",  out_a_bus,    '0);
        chk("s5_fire_now", W'(out_fire), W'(0));
        chk("s5_busy_now", W'(busy),     W'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        chk("s5_in_ready", W'(in_ready), W'(1));
        repeat (ROWS + 2) tick();
        chk("s5_no_done", W'(cnt_done), W'(0));
        single_tile();

        // Randomized tiles with random stalls and overlapping flushes.
        for (int t = 0; t < 20; t++) begin
            int len;
            len = $urandom_range(1, 10);
            for (int n = 0; n < len; n++) begin
                if ($urandom_range(0, 9) < 3) gap($urandom_range(1, 4));
                send({$urandom, $urandom, $urandom, $urandom}, n == len - 1);
            end
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
